// File: rtl/dpi_flow_sequencer_if.sv
// Bus bundles around the flow sequencer: payload byte stream, DFA engine char/state port,
// and match-report channel. The master modport is the side that drives valid/data.

interface seq_stream_if #(
    parameter int FLOW_W = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic [FLOW_W-1:0] s_flow;

    modport master (output s_valid, s_data, s_last, s_flow, input s_ready);
    modport slave  (input s_valid, s_data, s_last, s_flow, output s_ready);
endinterface

interface seq_dfa_if #(
    parameter int STATE_W = 11
);
    logic [7:0]         dfa_char;
    logic               dfa_char_vld;
    logic [STATE_W-1:0] dfa_state_in;
    logic               dfa_state_vld;
    logic [STATE_W-1:0] dfa_state_out;
    logic               dfa_accept;

    modport master (output dfa_char, dfa_char_vld, dfa_state_in, dfa_state_vld,
                    input dfa_state_out, dfa_accept);
    modport slave  (input dfa_char, dfa_char_vld, dfa_state_in, dfa_state_vld,
                    output dfa_state_out, dfa_accept);
endinterface

interface seq_rpt_if #(
    parameter int FLOW_W = 4,
    parameter int CNT_W  = 16
);
    logic              rpt_valid;
    logic              rpt_ready;
    logic [FLOW_W-1:0] rpt_flow;
    logic              rpt_match;
    logic [CNT_W-1:0]  rpt_count;
    logic [CNT_W-1:0]  rpt_first_off;

    modport master (output rpt_valid, rpt_flow, rpt_match, rpt_count, rpt_first_off,
                    input rpt_ready);
    modport slave  (input rpt_valid, rpt_flow, rpt_match, rpt_count, rpt_first_off,
                    output rpt_ready);
endinterface

// File: rtl/dpi_flow_sequencer.sv
// Per-packet sequencer for one regex DFA engine: restores the flow's saved DFA state,
// streams payload bytes, saves the final state per flow and emits one match report.

module dpi_flow_sequencer #(
    parameter int STATE_W = 11,
    parameter int FLOW_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_stream_if.slave       s,
    seq_dfa_if.master         dfa,
    seq_rpt_if.master         rpt,
    input  logic              flow_clr,
    input  logic [FLOW_W-1:0] flow_clr_id
);
    localparam int DEPTH = 2 ** FLOW_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_STREAM,
        ST_SAVE,
        ST_REPORT
    } state_e;

    state_e             state_q;
    logic [FLOW_W-1:0]  flow_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   first_off_q;
    logic               match_q;
    logic               s_ready_q;
    logic               state_vld_q;
    logic               rpt_valid_q;
    logic [DEPTH-1:0]   ctx_vld_q;
    logic [STATE_W-1:0] ctx_q [DEPTH];

    logic beat;
    assign beat = s.s_valid & s_ready_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values; this also lets the later flow_clr write override the SAVE write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flow_q      <= '0;
            count_q     <= '0;
            first_off_q <= '0;
            match_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            state_vld_q <= 1'b0;
            rpt_valid_q <= 1'b0;
            ctx_vld_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s.s_valid) begin
                        flow_q      <= s.s_flow;
                        count_q     <= '0;
                        first_off_q <= '0;
                        match_q     <= 1'b0;
                        state_vld_q <= 1'b1;
                        state_q     <= ST_RESTORE;
                    end
                end
                ST_RESTORE: begin
                    state_vld_q <= 1'b0;
                    s_ready_q   <= 1'b1;
                    state_q     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (beat) begin
                        if (!(&count_q)) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        // Offset is the pre-increment count of the first accepting byte.
                        if (dfa.dfa_accept && !match_q) begin
                            match_q     <= 1'b1;
                            first_off_q <= count_q;
                        end
                        if (s.s_last) begin
                            s_ready_q <= 1'b0;
                            state_q   <= ST_SAVE;
                        end
                    end
                end
                ST_SAVE: begin
                    ctx_vld_q[flow_q] <= 1'b1;
                    rpt_valid_q       <= 1'b1;
                    state_q           <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (rpt.rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (flow_clr) begin
                ctx_vld_q[flow_clr_id] <= 1'b0;
            end
        end
    end

    // NOTE: the context table has no reset; ctx_vld_q alone decides whether an entry is used.
    always_ff @(posedge clk) begin
        if (state_q == ST_SAVE) begin
            ctx_q[flow_q] <= dfa.dfa_state_out;
        end
    end

    assign s.s_ready         = s_ready_q;
    assign dfa.dfa_char      = s.s_data;
    assign dfa.dfa_char_vld  = beat;
    assign dfa.dfa_state_vld = state_vld_q;
    assign dfa.dfa_state_in  = (state_vld_q && ctx_vld_q[flow_q]) ? ctx_q[flow_q] : '0;

    assign rpt.rpt_valid     = rpt_valid_q;
    assign rpt.rpt_flow      = flow_q;
    assign rpt.rpt_match     = match_q;
    assign rpt.rpt_count     = count_q;
    assign rpt.rpt_first_off = first_off_q;

endmodule

// File: tb/tb_dpi_flow_sequencer.sv
// Directed bench for dpi_flow_sequencer with a toy DFA engine that accepts on 'C' (0x43)
// and whose state is the run length of consecutive 'C' bytes.

module tb_dpi_flow_sequencer;
    localparam int STATE_W = 11;
    localparam int FLOW_W  = 4;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              flow_clr;
    logic [FLOW_W-1:0] flow_clr_id;

    seq_stream_if #(.FLOW_W(FLOW_W))                 sif ();
    seq_dfa_if    #(.STATE_W(STATE_W))               dif ();
    seq_rpt_if    #(.FLOW_W(FLOW_W), .CNT_W(CNT_W)) rif ();

    int vectors     = 0;
    int miscompares = 0;

    int                 restore_pulses = 0;
    logic [STATE_W-1:0] last_restore   = '0;
    int                 proto_viol     = 0;
    int                 first_wait;
    logic [7:0]         pkt [$];

    always #5 clk = ~clk;

    dpi_flow_sequencer #(
        .STATE_W(STATE_W),
        .FLOW_W (FLOW_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (sif),
        .dfa        (dif),
        .rpt        (rif),
        .flow_clr   (flow_clr),
        .flow_clr_id(flow_clr_id)
    );

    // Engine model: registered state, combinational accept.
    logic [STATE_W-1:0] eng_state;
    always @(posedge clk) begin
        if (rst)                    eng_state <= '0;
        else if (dif.dfa_state_vld) eng_state <= dif.dfa_state_in;
        else if (dif.dfa_char_vld)  eng_state <= (dif.dfa_char == 8'h43) ? eng_state + 1'b1 : '0;
    end
    assign dif.dfa_state_out = eng_state;
    assign dif.dfa_accept    = dif.dfa_char_vld && (dif.dfa_char == 8'h43);

    always @(negedge clk) begin
        if (!rst) begin
            if (dif.dfa_state_vld) begin
                restore_pulses = restore_pulses + 1;
                last_restore   = dif.dfa_state_in;
            end
            if (dif.dfa_state_vld && dif.dfa_char_vld) proto_viol = proto_viol + 1;
            if (dif.dfa_char_vld !== (sif.s_valid && sif.s_ready)) proto_viol = proto_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [FLOW_W-1:0] flow, input bit gaps);
        int i = 0;
        int cyc = 0;
        int limit;
        bit took;
        bit v;
        limit = 2 * pkt.size() + 64;
        first_wait = -1;
        while (i < pkt.size() && cyc < limit) begin
            v = !gaps || ($urandom_range(0, 15) != 0);
            sif.s_valid = v;
            sif.s_flow  = flow;
            sif.s_data  = pkt[i];
            sif.s_last  = (i == pkt.size() - 1);
            took = v && sif.s_ready;
            if (took && first_wait < 0) first_wait = cyc;
            tick();
            cyc = cyc + 1;
            if (took) i = i + 1;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        check("send_done", i == pkt.size(), 1);
    endtask

    task automatic expect_rpt(input string tag, input logic [FLOW_W-1:0] flow,
                              input logic match, input logic [CNT_W-1:0] cnt,
                              input logic [CNT_W-1:0] off);
        int n = 0;
        while (!rif.rpt_valid && n < 16) begin
            tick();
            n = n + 1;
        end
        check({tag, "_valid"}, rif.rpt_valid, 1);
        check({tag, "_flow"}, rif.rpt_flow, flow);
        check({tag, "_match"}, rif.rpt_match, match);
        check({tag, "_count"}, rif.rpt_count, cnt);
        check({tag, "_first_off"}, rif.rpt_first_off, off);
        rif.rpt_ready = 1'b1;
        tick();
        rif.rpt_ready = 1'b0;
        check({tag, "_done"}, rif.rpt_valid, 0);
    endtask

    initial begin
        int p0;
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        sif.s_flow  = '0;
        rif.rpt_ready = 1'b0;
        flow_clr    = 1'b0;
        flow_clr_id = '0;
        tick();
        tick();
        check("rst_s_ready", sif.s_ready, 0);
        check("rst_rpt_valid", rif.rpt_valid, 0);
        check("rst_state_vld", dif.dfa_state_vld, 0);
        check("rst_char_vld", dif.dfa_char_vld, 0);
        check("rst_rpt_count", rif.rpt_count, 0);
        check("rst_rpt_flow", rif.rpt_flow, 0);
        check("rst_rpt_match", rif.rpt_match, 0);
        check("rst_rpt_off", rif.rpt_first_off, 0);
        rst = 1'b0;
        tick();

        // 1: basic packet, latency and single restore pulse
        pkt = '{8'h41, 8'h42, 8'h43, 8'h44};
        p0 = restore_pulses;
        send_pkt(3, 1'b0);
        check("t1_first_lat", first_wait, 2);
        check("t1_save_no_rpt", rif.rpt_valid, 0);
        tick();
        check("t1_rpt_lat", rif.rpt_valid, 1);
        expect_rpt("t1", 3, 1'b1, 16'd4, 16'd2);
        check("t1_pulses", restore_pulses - p0, 1);
        check("t1_restore", last_restore, 0);

        // 2: flow 5 context save/restore, then clear
        pkt = '{8'h41, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43};
        send_pkt(5, 1'b0);
        expect_rpt("t2a", 5, 1'b1, 16'd8, 16'd1);
        pkt = '{8'h41};
        send_pkt(5, 1'b0);
        check("t2_restore7", last_restore, 7);
        expect_rpt("t2b", 5, 1'b0, 16'd1, 16'd0);
        flow_clr    = 1'b1;
        flow_clr_id = 4'd5;
        tick();
        flow_clr    = 1'b0;
        pkt = '{8'h44, 8'h43};
        send_pkt(5, 1'b0);
        check("t2_restore_clr", last_restore, 0);
        expect_rpt("t2c", 5, 1'b1, 16'd2, 16'd1);

        // 3: clear in the SAVE cycle of the same flow wins
        pkt = '{8'h43, 8'h43};
        send_pkt(6, 1'b0);
        check("t3_in_save", rif.rpt_valid, 0);
        flow_clr    = 1'b1;
        flow_clr_id = 4'd6;
        tick();
        flow_clr    = 1'b0;
        expect_rpt("t3a", 6, 1'b1, 16'd2, 16'd0);
        pkt = '{8'h41};
        send_pkt(6, 1'b0);
        check("t3_restore", last_restore, 0);
        expect_rpt("t3b", 6, 1'b0, 16'd1, 16'd0);

        // 4: report backpressure with a new packet already waiting
        pkt = '{8'h43};
        send_pkt(2, 1'b0);
        tick();
        sif.s_valid = 1'b1;
        sif.s_flow  = 4'd9;
        sif.s_data  = 8'h41;
        sif.s_last  = 1'b1;
        p0 = restore_pulses;
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", rif.rpt_valid, 1);
            check("t4_hold_flow", rif.rpt_flow, 2);
            check("t4_hold_count", rif.rpt_count, 1);
            check("t4_hold_match", rif.rpt_match, 1);
            check("t4_hold_off", rif.rpt_first_off, 0);
            check("t4_hold_s_ready", sif.s_ready, 0);
            tick();
        end
        check("t4_no_restore", restore_pulses - p0, 0);
        rif.rpt_ready = 1'b1;
        tick();
        rif.rpt_ready = 1'b0;
        check("t4_rpt_dropped", rif.rpt_valid, 0);
        check("t4_idle_no_vld", dif.dfa_state_vld, 0);
        tick();
        check("t4_restore_vld", dif.dfa_state_vld, 1);
        tick();
        check("t4_stream_ready", sif.s_ready, 1);
        tick();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        expect_rpt("t4b", 9, 1'b0, 16'd1, 16'd0);

        // 5: long packet with gaps, count saturates
        pkt.delete();
        for (int i = 0; i < 70000; i++) begin
            pkt.push_back((i == 40000) ? 8'h43 : 8'h30 + 8'(i % 3));
        end
        send_pkt(7, 1'b1);
        expect_rpt("t5", 7, 1'b1, 16'hFFFF, 16'd40000);

        // 6: reset mid-stream drops the packet and invalidates all contexts
        sif.s_valid = 1'b1;
        sif.s_flow  = 4'd5;
        sif.s_data  = 8'h41;
        sif.s_last  = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_s_ready", sif.s_ready, 0);
        check("t6_rpt_valid", rif.rpt_valid, 0);
        check("t6_state_vld", dif.dfa_state_vld, 0);
        check("t6_rpt_count", rif.rpt_count, 0);
        tick();
        tick();
        check("t6_no_rpt", rif.rpt_valid, 0);
        pkt = '{8'h43};
        send_pkt(5, 1'b0);
        check("t6_restore", last_restore, 0);
        expect_rpt("t6", 5, 1'b1, 16'd1, 16'd0);

        check("proto", proto_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
